// File: rtl/nv_nvdla_cdma_img_rsp_unpack.sv
// CDMA image read-response unpacker: splits 514-bit DMA responses into 256-bit atoms.
// Optional perf counter built when NVDLA_CDMA_IMG_UNPACK_PERF_EN is defined.
module nv_nvdla_cdma_img_rsp_unpack #(
  parameter int DATA_W = 512,
  parameter int ATOM_W = 256,
  parameter int MASK_W = 2
) (
  input  logic                       nvdla_core_clk,
  input  logic                       nvdla_core_rstn,
  input  logic [DATA_W+MASK_W-1:0]   rsp_pd,
  input  logic                       rsp_vld,
  output logic                       rsp_rdy,
  output logic [ATOM_W-1:0]          atom_pd,
  output logic                       atom_vld,
  input  logic                       atom_rdy,
  output logic                       atom_half,
  output logic                       atom_last,
`ifdef NVDLA_CDMA_IMG_UNPACK_PERF_EN
  input  logic                       perf_cnt_clr,
  output logic [31:0]                perf_atom_cnt,
`endif
  output logic                       mask_err
);

  // Handshake: a transfer happens on a cycle where valid and ready are both high at
  // the rising clock edge; valid never depends on ready, ready may depend on valid.

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t              state;
  logic [DATA_W-1:0]   data_q;
  logic [MASK_W-1:0]   rem_q;
  logic [MASK_W-1:0]   rem_nxt;
  logic [MASK_W-1:0]   rsp_mask;
  logic                cur_half;
  logic                accept;
  logic                emit;
  logic                mask_err_q;

  assign rsp_mask = rsp_pd[DATA_W +: MASK_W];
  assign mask_err = mask_err_q;

  always_comb begin
    state     = (rem_q == '0) ? EMPTY : HOLD;
    // Lowest pending half: high only when the low half is already gone.
    cur_half  = rem_q[1] & ~rem_q[0];
    atom_vld  = (state == HOLD);
    atom_half = cur_half;
    atom_last = rem_q[0] ^ rem_q[1];
    atom_pd   = cur_half ? data_q[ATOM_W +: ATOM_W] : data_q[0 +: ATOM_W];
    emit      = atom_vld & atom_rdy;
    rsp_rdy   = (state == EMPTY) | (emit & atom_last);
    accept    = rsp_vld & rsp_rdy;
    rem_nxt   = rem_q;
    if (accept) begin
      rem_nxt = rsp_mask;
    end else if (emit) begin
      rem_nxt = cur_half ? (rem_q & 2'b01) : (rem_q & 2'b10);
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      data_q     <= '0;
      rem_q      <= '0;
      mask_err_q <= 1'b0;
    end else begin
      rem_q      <= rem_nxt;
      mask_err_q <= accept & (rsp_mask == '0);
      if (accept) begin
        data_q <= rsp_pd[DATA_W-1:0];
      end
    end
  end

`ifdef NVDLA_CDMA_IMG_UNPACK_PERF_EN
  logic [31:0] perf_cnt_q;
  assign perf_atom_cnt = perf_cnt_q;

  // Clear takes priority; the count saturates instead of wrapping.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      perf_cnt_q <= '0;
    end else if (perf_cnt_clr) begin
      perf_cnt_q <= '0;
    end else if (emit && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_q <= perf_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nv_nvdla_cdma_img_rsp_unpack.sv
// Bench for nv_nvdla_cdma_img_rsp_unpack; perf tests build when NVDLA_CDMA_IMG_UNPACK_PERF_EN is defined.
module tb_nv_nvdla_cdma_img_rsp_unpack;

  logic         clk;
  logic         rstn;
  logic [513:0] rsp_pd;
  logic         rsp_vld;
  logic         rsp_rdy;
  logic [255:0] atom_pd;
  logic         atom_vld;
  logic         atom_rdy;
  logic         atom_half;
  logic         atom_last;
  logic         mask_err;
`ifdef NVDLA_CDMA_IMG_UNPACK_PERF_EN
  logic         perf_cnt_clr;
  logic [31:0]  perf_atom_cnt;
`endif

  nv_nvdla_cdma_img_rsp_unpack dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .rsp_pd          (rsp_pd),
    .rsp_vld         (rsp_vld),
    .rsp_rdy         (rsp_rdy),
    .atom_pd         (atom_pd),
    .atom_vld        (atom_vld),
    .atom_rdy        (atom_rdy),
    .atom_half       (atom_half),
    .atom_last       (atom_last),
`ifdef NVDLA_CDMA_IMG_UNPACK_PERF_EN
    .perf_cnt_clr    (perf_cnt_clr),
    .perf_atom_cnt   (perf_atom_cnt),
`endif
    .mask_err        (mask_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [257:0] exp_q[$];   // {half, last, pd}
  int total = 0;
  int bad = 0;
  int emit_n = 0;
  int first_emit = -1;
  int last_emit = -1;
  int err_pulses = 0;
  int exp_err_pulses = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk(input logic [7:0] lo, input logic [7:0] hi);
    return {{32{hi}}, {32{lo}}};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rstn) begin
      if (mask_err) err_pulses++;
      if (atom_vld) chk("rsp_rdy_hold", rsp_rdy, atom_rdy & atom_last);
      else          chk("rsp_rdy_empty", rsp_rdy, 1'b1);
      if (atom_vld && atom_rdy) begin
        emit_n++;
        if (first_emit < 0) first_emit = cyc;
        last_emit = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_atom", {atom_half, atom_last, atom_pd}, '0);
        end else begin
          logic [257:0] e;
          e = exp_q.pop_front();
          chk("atom_half", atom_half, e[257]);
          chk("atom_last", atom_last, e[256]);
          chk("atom_pd", atom_pd, e[255:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_rsp(input logic [1:0] m, input logic [511:0] d);
    int n;
    bit acc;
    n = 0;
    acc = 0;
    rsp_pd = {m, d};
    rsp_vld = 1'b1;
    if (m[0]) exp_q.push_back({1'b0, (m == 2'b01), d[255:0]});
    if (m[1]) exp_q.push_back({1'b1, 1'b1, d[511:256]});
    if (m == 2'b00) exp_err_pulses++;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = rsp_rdy;
      n++;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle_rsp();
    rsp_vld = 1'b0;
    rsp_pd = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0;
    rsp_pd = '0;
    rsp_vld = 1'b0;
    atom_rdy = 1'b0;
`ifdef NVDLA_CDMA_IMG_UNPACK_PERF_EN
    perf_cnt_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_rsp_rdy", rsp_rdy, 1'b1);
    chk("reset_atom_vld", atom_vld, 1'b0);
    chk("reset_atom_pd", atom_pd, '0);
    chk("reset_atom_half", atom_half, 1'b0);
    chk("reset_atom_last", atom_last, 1'b0);
    chk("reset_mask_err", mask_err, 1'b0);

    // Four dual-atom responses, no backpressure: 8 atoms on consecutive cycles.
    atom_rdy = 1'b1;
    emit_n = 0;
    first_emit = -1;
    send_rsp(2'b11, mk(8'h10, 8'h11));
    chk("latency_vld", atom_vld, 1'b1);
    send_rsp(2'b11, mk(8'h20, 8'h21));
    send_rsp(2'b11, mk(8'h30, 8'h31));
    send_rsp(2'b11, mk(8'h40, 8'h41));
    idle_rsp();
    drain();
    chk("stream_count", emit_n, 8);
    chk("stream_span", last_emit - first_emit, 7);

    // Mixed masks back to back; 00 is dropped with a one-cycle error pulse.
    send_rsp(2'b01, mk(8'h51, 8'hE1));
    send_rsp(2'b10, mk(8'hE2, 8'h62));
    send_rsp(2'b00, mk(8'hE3, 8'hE3));
    chk("mask_err_pulse", mask_err, 1'b1);
    send_rsp(2'b11, mk(8'h74, 8'h84));
    chk("mask_err_single", mask_err, 1'b0);
    idle_rsp();
    drain();

    // Stall: first atom must hold steady while ready is low.
    atom_rdy = 1'b0;
    send_rsp(2'b11, mk(8'hA5, 8'h5A));
    idle_rsp();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_vld", atom_vld, 1'b1);
      chk("stall_pd", atom_pd, mk(8'hA5, 8'h5A) & {256'b0, {256{1'b1}}});
      chk("stall_half", atom_half, 1'b0);
      chk("stall_rsp_rdy", rsp_rdy, 1'b0);
      @(posedge clk);
      #1;
    end
    atom_rdy = 1'b1;
    drain();

    // Reset while the high half is pending.
    atom_rdy = 1'b0;
    send_rsp(2'b11, mk(8'hC3, 8'h3C));
    idle_rsp();
    atom_rdy = 1'b1;
    @(posedge clk);
    #1;
    atom_rdy = 1'b0;
    chk("pre_reset_half", atom_half, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("async_reset_vld", atom_vld, 1'b0);
    chk("async_reset_rdy", rsp_rdy, 1'b1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(posedge clk);
    #1 rstn = 1'b1;
    atom_rdy = 1'b1;
    send_rsp(2'b11, mk(8'h96, 8'h69));
    idle_rsp();
    drain();

`ifdef NVDLA_CDMA_IMG_UNPACK_PERF_EN
    perf_cnt_clr = 1'b1;
    @(posedge clk);
    #1 perf_cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) send_rsp(2'b11, mk(8'(i), 8'(i + 8'h80)));
    idle_rsp();
    drain();
    chk("perf_ten", perf_atom_cnt, 32'd10);
    send_rsp(2'b01, mk(8'hD1, 8'h00));
    idle_rsp();
    perf_cnt_clr = 1'b1;
    @(posedge clk);
    #1 perf_cnt_clr = 1'b0;
    chk("perf_clr_wins", perf_atom_cnt, 32'd0);
    drain();
    force dut.perf_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.perf_cnt_q;
    send_rsp(2'b11, mk(8'hD2, 8'hD3));
    send_rsp(2'b01, mk(8'hD4, 8'h00));
    idle_rsp();
    drain();
    chk("perf_saturate", perf_atom_cnt, 32'hFFFF_FFFF);
`endif

    chk("mask_err_total", err_pulses, exp_err_pulses);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nv_nvdla_cdma_img_rsp_unpack.md
Name: nv_nvdla_cdma_img_rsp_unpack

Overview:
- Consumes 514-bit DMA read responses from the CDMA image read-response pipe stage (cv_dma_rd_rsp_*). Payload is 512-bit data plus a 2-bit half-mask in bits [513:512].
- Splits each response into 256-bit atoms, emitting one atom per cycle to the image packer over a valid/ready handshake.
- Drives backpressure (rsp_rdy) directly into the upstream skid stage.

Parameters:
- DATA_W, 512, response data width.
- ATOM_W, 256, output atom width (DATA_W/2).
- MASK_W, 2, mask width; bit i set means half i (bits [i*256+255:i*256]) is valid.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  asynchronous active-low reset.
- rsp_pd  in  514  response payload; [511:0] data, [513:512] mask.
- rsp_vld  in  1  response valid.
- rsp_rdy  out  1  response ready.
- atom_pd  out  256  atom data.
- atom_vld  out  1  atom valid.
- atom_rdy  in  1  atom ready from packer.
- atom_half  out  1  source half of the current atom (0 = low, 1 = high).
- atom_last  out  1  current atom is the final atom of its response.
- mask_err  out  1  one-cycle pulse when a response with mask 2'b00 is accepted.

Behaviour:
- Clock and reset: clock nvdla_core_clk; reset nvdla_core_rstn, asynchronous, active-low.
- Reset values: atom_vld=0, atom_pd=0, atom_half=0, atom_last=0, mask_err=0. rsp_rdy=1 immediately after reset deassertion.
- Storage: one hold register (512 data + 2-bit remaining mask rem). The data register is reset to 0.
- States:
  - EMPTY: rem==0.
  - HOLD: rem!=0.
- Transfers:
  - Accept = rsp_vld & rsp_rdy.
  - Emit = atom_vld & atom_rdy.
- Outputs in HOLD:
  - atom_vld=1.
  - Current half h = lowest set bit of rem.
  - atom_pd = data[h*256 +: 256]; atom_half = h.
  - atom_last = 1 iff rem has exactly one bit set.
- Outputs in EMPTY: atom_vld=0.
- rsp_rdy = EMPTY | (Emit & atom_last). This is a combinational path from atom_rdy. Both back-to-back single-atom and dual-atom responses run with zero bubbles.
- On Accept: load data and rem <= mask. The first atom is valid the next cycle (latency 1 cycle, accept to atom_vld).
- On Emit without Accept: clear bit h in rem; data is unchanged.
- Emit of the last atom with a simultaneous Accept: the new response loads and overrides the clear.
- Mask 2'b00:
  - The response is accepted and dropped; no atom is produced.
  - mask_err pulses high in the cycle after accept.
  - The block stays EMPTY.
- Mask 2'b10: a single atom, high half, atom_last=1.
- Mask 2'b11: the low atom (atom_last=0) is emitted first, then the high atom (atom_last=1).
- Stall (atom_vld=1, atom_rdy=0): atom_pd, atom_half and atom_last stay stable, and rsp_rdy=0.
- Reset mid-operation: the hold contents and rem are discarded, and the block returns to EMPTY in the same cycle (asynchronous).
- Ordering: atoms leave in response arrival order, low half before high half within a response.

Optional Feature:
- Macro: NVDLA_CDMA_IMG_UNPACK_PERF_EN.
- Defined: adds output perf_atom_cnt [31:0].
  - Increments by 1 on each Emit and saturates at 0xFFFFFFFF.
  - Adds input perf_cnt_clr [1]. When perf_cnt_clr is high, the next value is 0, and clear wins over a simultaneous Emit.
  - perf_atom_cnt resets to 0.
- Undefined: neither port exists and no counter logic is built. All other behaviour is identical.

Test Plan:
- Reset, then idle -> rsp_rdy=1, atom_vld=0, atom_pd=0, mask_err=0.
- Stream of 4 responses with mask 2'b11, atom_rdy held at 1 -> 8 atoms on 8 consecutive cycles starting one cycle after the first accept.
  - atom_half alternates 0,1; atom_last=0,1.
  - rsp_rdy is high only on last-atom cycles after the first accept.
- Responses with masks 01, 10, 00, 11 back-to-back, no backpressure -> atom sequence (low,last), (high,last), (low), (high,last).
  - mask_err pulses once, one cycle after the 00 response is accepted.
- Mask 11 response with data low=0xA5.., high=0x5A.., atom_rdy=0 for 5 cycles after the first atom appears -> atom_pd=0xA5.. and atom_half=0 stable, rsp_rdy=0 throughout.
  - Releasing atom_rdy gives 0xA5.. then 0x5A..
- Assert reset while holding the high half of a mask 11 response -> atom_vld=0 and rsp_rdy=1 immediately.
  - The next response is output correctly with no stale atom.
- With NVDLA_CDMA_IMG_UNPACK_PERF_EN defined: emit 10 atoms -> perf_atom_cnt=10.
  - perf_cnt_clr high together with an Emit -> 0.
  - Preload (force) the counter to 0xFFFFFFFE and emit 3 atoms -> 0xFFFFFFFF.
